// File: rtl/mul12_share_arbiter.sv
// mul12_share_arbiter
// Shares one external combinational 12x12 unsigned multiplier among NREQ
// requesters. Requests are granted round-robin, operands are registered onto
// the multiplier for MUL_LAT cycles, and the product is captured into a single
// response buffer tagged with the owning requester id.
//
// Build option: define MUL_ARB_FIXED_PRIO_EN to replace round-robin with fixed
// priority (lowest index wins; the rr pointer then stays at its reset value).

module mul12_share_arbiter #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int MUL_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid_in,
    output logic [NREQ-1:0]      req_ready_out,
    input  logic [NREQ*12-1:0]   req_x_in,
    input  logic [NREQ*12-1:0]   req_y_in,
    output logic [11:0]          mul_x_out,
    output logic [11:0]          mul_y_out,
    input  logic [23:0]          mul_result_in,
    output logic                 rsp_valid_out,
    output logic [IDW-1:0]       rsp_id_out,
    output logic [23:0]          rsp_data_out,
    input  logic                 rsp_ready_in,
    output logic                 busy_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Reset pointer value so that requester 0 is searched first.
    localparam logic [IDW-1:0] RR_RST = IDW'(NREQ - 1);
    localparam logic [2:0]     LAT_LD = 3'(MUL_LAT - 1);

    state_t            state_q, state_d;
    logic [IDW-1:0]    rr_q, rr_d;
    logic [IDW-1:0]    id_q, id_d;
    logic [2:0]        lat_q, lat_d;
    logic [11:0]       mul_x_q, mul_x_d;
    logic [11:0]       mul_y_q, mul_y_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]    rsp_id_q, rsp_id_d;
    logic [23:0]       rsp_data_q, rsp_data_d;
    logic              busy_q, busy_d;

    logic              win_open_s;
    logic [IDW:0]      pick_s;
    logic              found_s;
    logic [IDW-1:0]    gnt_idx_s;
    logic [NREQ-1:0]   ready_s;
    logic              accept_s;

    // Returns {found, index} of the winning requester. The loop runs from the
    // farthest candidate to the nearest so the nearest valid one is kept last.
    function automatic logic [IDW:0] pick_f(input logic [NREQ-1:0] v,
                                            input logic [IDW-1:0]  ptr);
        logic [IDW:0] r;
        int           idx;
        r = '0;
        for (int k = NREQ; k >= 1; k--) begin
`ifdef MUL_ARB_FIXED_PRIO_EN
            idx = k - 1;
`else
            idx = (int'(ptr) + k) % NREQ;
`endif
            if (v[IDW'(idx)]) begin
                r = {1'b1, IDW'(idx)};
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // Grant window and one-hot ready; forced low while reset is asserted.
    always_comb begin
        win_open_s = (state_q == IDLE) || ((state_q == RESP) && rsp_ready_in);
        pick_s     = pick_f(req_valid_in, rr_q);
        found_s    = pick_s[IDW];
        gnt_idx_s  = pick_s[IDW-1:0];
        ready_s    = '0;
        if (rst_n && win_open_s && found_s) begin
            ready_s = NREQ'(1) << gnt_idx_s;
        end else begin
            ready_s = '0;
        end
        accept_s = |(req_valid_in & ready_s);
    end

    // Next-state and next-output computation for the transaction FSM.
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        id_d        = id_q;
        lat_d       = lat_q;
        mul_x_d     = mul_x_q;
        mul_y_d     = mul_y_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;

        case (state_q)
            IDLE: begin
                rsp_valid_d = 1'b0;
            end
            EXEC: begin
                if (lat_q == 3'd0) begin
                    rsp_data_d  = mul_result_in;
                    rsp_id_d    = id_q;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    lat_d = lat_q - 3'd1;
                end
            end
            RESP: begin
                if (rsp_ready_in) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase

        // An accept can only happen in an open window (IDLE or draining RESP),
        // so it overrides the IDLE/RESP transitions chosen above.
        if (accept_s) begin
            mul_x_d = req_x_in[12*gnt_idx_s +: 12];
            mul_y_d = req_y_in[12*gnt_idx_s +: 12];
            id_d    = gnt_idx_s;
`ifdef MUL_ARB_FIXED_PRIO_EN
            rr_d    = rr_q;
`else
            rr_d    = gnt_idx_s;
`endif
            lat_d   = LAT_LD;
            state_d = EXEC;
        end else begin
            rr_d = rr_d;
        end

        busy_d = (state_d != IDLE);
    end

    // State and registered-output flops; reset drops any in-flight work.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_q        <= RR_RST;
            id_q        <= '0;
            lat_q       <= 3'd0;
            mul_x_q     <= 12'd0;
            mul_y_q     <= 12'd0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= 24'd0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            id_q        <= id_d;
            lat_q       <= lat_d;
            mul_x_q     <= mul_x_d;
            mul_y_q     <= mul_y_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            busy_q      <= busy_d;
        end
    end

    assign req_ready_out = ready_s;
    assign mul_x_out     = mul_x_q;
    assign mul_y_out     = mul_y_q;
    assign rsp_valid_out = rsp_valid_q;
    assign rsp_id_out    = rsp_id_q;
    assign rsp_data_out  = rsp_data_q;
    assign busy_out      = busy_q;

endmodule

// File: tb/tb_mul12_share_arbiter.sv
// Bench for mul12_share_arbiter: a MUL_LAT=1 instance driven by table vectors
// and directed sequences with a response scoreboard, plus a MUL_LAT=3 instance.

module tb_mul12_share_arbiter;

    logic        clk;
    logic        rst_n;

    // MUL_LAT = 1 instance
    logic [3:0]  valid;
    logic [3:0]  ready;
    logic [11:0] opx [4];
    logic [11:0] opy [4];
    logic [47:0] req_x;
    logic [47:0] req_y;
    logic [11:0] mx, my;
    logic [23:0] mres;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [23:0] rsp_data;
    logic        rsp_ready;
    logic        busy;

    // MUL_LAT = 3 instance
    logic [3:0]  valid3;
    logic [3:0]  ready3;
    logic [11:0] opx3 [4];
    logic [11:0] opy3 [4];
    logic [47:0] req_x3;
    logic [47:0] req_y3;
    logic [11:0] mx3, my3;
    logic [23:0] mres3;
    logic        rsp_valid3;
    logic [1:0]  rsp_id3;
    logic [23:0] rsp_data3;
    logic        rsp_ready3;
    logic        busy3;

    assign req_x  = {opx[3], opx[2], opx[1], opx[0]};
    assign req_y  = {opy[3], opy[2], opy[1], opy[0]};
    assign req_x3 = {opx3[3], opx3[2], opx3[1], opx3[0]};
    assign req_y3 = {opy3[3], opy3[2], opy3[1], opy3[0]};

    // Behavioural stand-in for the shared multiplier.
    assign mres  = 24'(mx) * 24'(my);
    assign mres3 = 24'(mx3) * 24'(my3);

    mul12_share_arbiter #(.NREQ(4), .IDW(2), .MUL_LAT(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_in(valid), .req_ready_out(ready),
        .req_x_in(req_x), .req_y_in(req_y),
        .mul_x_out(mx), .mul_y_out(my), .mul_result_in(mres),
        .rsp_valid_out(rsp_valid), .rsp_id_out(rsp_id), .rsp_data_out(rsp_data),
        .rsp_ready_in(rsp_ready), .busy_out(busy)
    );

    mul12_share_arbiter #(.NREQ(4), .IDW(2), .MUL_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid_in(valid3), .req_ready_out(ready3),
        .req_x_in(req_x3), .req_y_in(req_y3),
        .mul_x_out(mx3), .mul_y_out(my3), .mul_result_in(mres3),
        .rsp_valid_out(rsp_valid3), .rsp_id_out(rsp_id3), .rsp_data_out(rsp_data3),
        .rsp_ready_in(rsp_ready3), .busy_out(busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] x;
        logic [11:0] y;
        logic [23:0] exp;
    } vec_t;

    typedef struct {
        logic [1:0]  id;
        logic [23:0] data;
    } rsp_t;

    vec_t  vecs [6];
    rsp_t  sb [$];
    int    grant_log [$];
    int    checks;
    int    errors;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Observe the handshakes that the coming rising edge will act on, then
    // advance to the next falling edge.
    task automatic step();
        rsp_t e;
        #1;
        if (rst_n) begin
            for (int i = 0; i < 4; i++) begin
                if (ready[i] && valid[i]) begin
                    e.id   = 2'(i);
                    e.data = 24'(opx[i]) * 24'(opy[i]);
                    sb.push_back(e);
                    grant_log.push_back(i);
                end
            end
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("sb_id", 32'(rsp_id), 32'(e.id));
                    chk("sb_data", 32'(rsp_data), 32'(e.data));
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sb.delete();
        grant_log.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        vecs[0] = '{x: 12'hFFF, y: 12'hFFF, exp: 24'hFFE001};
        vecs[1] = '{x: 12'd3,   y: 12'd5,   exp: 24'd15};
        vecs[2] = '{x: 12'd0,   y: 12'hABC, exp: 24'd0};
        vecs[3] = '{x: 12'd1,   y: 12'hFFF, exp: 24'h000FFF};
        vecs[4] = '{x: 12'd2048, y: 12'd2,  exp: 24'd4096};
        vecs[5] = '{x: 12'h800, y: 12'h800, exp: 24'h400000};

        valid = 4'b0; rsp_ready = 1'b1;
        valid3 = 4'b0; rsp_ready3 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            opx[i] = 12'd0; opy[i] = 12'd0; opx3[i] = 12'd0; opy3[i] = 12'd0;
        end
        rst_n = 1'b0;
        @(negedge clk);

        // Reset state: ready held low even with every request valid.
        valid = 4'hF;
        #1;
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mul_x", 32'(mx), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        valid = 4'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Table vectors through requester 0.
        for (int v = 0; v < 6; v++) begin
            opx[0] = vecs[v].x; opy[0] = vecs[v].y;
            valid = 4'b0001; rsp_ready = 1'b1;
            #1;
            chk("vec_ready", 32'(ready), 32'h1);
            step();
            valid = 4'b0;
            chk("vec_exec_ready", 32'(ready), 32'd0);
            chk("vec_busy", 32'(busy), 32'd1);
            chk("vec_mul_x", 32'(mx), 32'(vecs[v].x));
            chk("vec_valid_early", 32'(rsp_valid), 32'd0);
            step();
            chk("vec_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("vec_rsp_id", 32'(rsp_id), 32'd0);
            chk("vec_rsp_data", 32'(rsp_data), 32'(vecs[v].exp));
            step();
            chk("vec_drain_valid", 32'(rsp_valid), 32'd0);
            chk("vec_data_held", 32'(rsp_data), 32'(vecs[v].exp));
            chk("vec_mul_x_held", 32'(mx), 32'(vecs[v].x));
        end

`ifdef MUL_ARB_FIXED_PRIO_EN
        // Fixed priority: req0 always beats req2 while both are valid.
        do_reset();
        opx[0] = 12'd11; opy[0] = 12'd13; opx[2] = 12'd17; opy[2] = 12'd19;
        valid = 4'b0101; rsp_ready = 1'b1;
        for (int c = 0; c < 8; c++) step();
        chk("fp_grant_count", 32'(grant_log.size()), 32'd4);
        foreach (grant_log[i]) chk("fp_grant_req0", 32'(grant_log[i]), 32'd0);
        grant_log.delete();
        valid = 4'b0100;
        for (int c = 0; c < 4; c++) step();
        chk("fp_grant2_count", 32'(grant_log.size()), 32'd2);
        foreach (grant_log[i]) chk("fp_grant_req2", 32'(grant_log[i]), 32'd2);
        valid = 4'b0;
        for (int c = 0; c < 3; c++) step();
`else
        // All four requesters continuously valid: round-robin 0,1,2,3,0.
        do_reset();
        opx[0] = 12'd3;   opy[0] = 12'd5;
        opx[1] = 12'd7;   opy[1] = 12'd9;
        opx[2] = 12'd100; opy[2] = 12'd200;
        opx[3] = 12'd4095; opy[3] = 12'd1;
        valid = 4'hF; rsp_ready = 1'b1;
        for (int c = 0; c < 10; c++) step();
        valid = 4'b0;
        for (int c = 0; c < 3; c++) step();
        chk("rr_grant_count", 32'(grant_log.size()), 32'd5);
        if (grant_log.size() == 5) begin
            chk("rr_order0", 32'(grant_log[0]), 32'd0);
            chk("rr_order1", 32'(grant_log[1]), 32'd1);
            chk("rr_order2", 32'(grant_log[2]), 32'd2);
            chk("rr_order3", 32'(grant_log[3]), 32'd3);
            chk("rr_order4", 32'(grant_log[4]), 32'd0);
        end else begin
            chk("rr_order_len", 32'(grant_log.size()), 32'd5);
        end
`endif

        // Backpressure with req1 pending.
        do_reset();
        opx[0] = 12'd10; opy[0] = 12'd20; opx[1] = 12'd30; opy[1] = 12'd40;
        valid = 4'b0001; rsp_ready = 1'b1;
        step();
        valid = 4'b0010; rsp_ready = 1'b0;
        #1;
        chk("bp_exec_ready", 32'(ready), 32'd0);
        step();
        for (int c = 0; c < 10; c++) begin
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_data", 32'(rsp_data), 32'd200);
            chk("bp_id", 32'(rsp_id), 32'd0);
            chk("bp_ready", 32'(ready), 32'd0);
            step();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_grant", 32'(ready), 32'b0010);
        step();
        valid = 4'b0;
        chk("bp_exec_valid", 32'(rsp_valid), 32'd0);
        step();
        chk("bp_rsp2_data", 32'(rsp_data), 32'd1200);
        chk("bp_rsp2_id", 32'(rsp_id), 32'd1);
        step();

        // Reset while req3 is executing.
        do_reset();
        opx[3] = 12'd5; opy[3] = 12'd6;
        valid = 4'b1000; rsp_ready = 1'b1;
        step();
        valid = 4'b0;
        chk("mr_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_mul_x", 32'(mx), 32'd0);
        chk("mr_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mr_ready", 32'(ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        sb.delete();
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            chk("mr_no_rsp", 32'(rsp_valid), 32'd0);
            step();
        end
        opx[0] = 12'd2; opy[0] = 12'd9;
        valid = 4'b1001;
        #1;
        chk("mr_first_grant", 32'(ready), 32'b0001);
        step();
        valid = 4'b0;
        for (int c = 0; c < 3; c++) step();

        // MUL_LAT = 3 instance: req2, 2048 * 2.
        opx3[2] = 12'd2048; opy3[2] = 12'd2;
        valid3 = 4'b0100; rsp_ready3 = 1'b1;
        #1;
        chk("l3_ready", 32'(ready3), 32'b0100);
        @(negedge clk);
        valid3 = 4'b0;
        for (int c = 0; c < 3; c++) begin
            chk("l3_mul_x_hold", 32'(mx3), 32'd2048);
            chk("l3_not_valid", 32'(rsp_valid3), 32'd0);
            @(negedge clk);
        end
        chk("l3_rsp_valid", 32'(rsp_valid3), 32'd1);
        chk("l3_rsp_data", 32'(rsp_data3), 32'd4096);
        chk("l3_rsp_id", 32'(rsp_id3), 32'd2);
        @(negedge clk);
        chk("l3_drain", 32'(rsp_valid3), 32'd0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul12_share_arbiter.md
Name: mul12_share_arbiter

Overview:
- Shares one combinational 12x12 unsigned Wallace multiplier (24-bit product) among NREQ requesters.
- Per-requester valid/ready request ports, round-robin grant.
- Drives registered operands to the multiplier, holds them for MUL_LAT cycles, then captures the product into a single response buffer tagged with the requester id.
- Sits between client engines and the shared multiplier instance.

Parameters:
- NREQ, 4, number of requesters (2..8)
- IDW, 2, width of requester id; must satisfy 2^IDW >= NREQ
- MUL_LAT, 1, cycles operands are held on the multiplier before the product is captured (1..4)

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid_in  input  NREQ  request valid, bit i = requester i
- req_ready_out  output  NREQ  one-hot accept; at most one bit high per cycle
- req_x_in  input  NREQ*12  multiplicand; requester i uses bits [12i+11:12i]
- req_y_in  input  NREQ*12  multiplier; requester i uses bits [12i+11:12i]
- mul_x_out  output  12  operand x to the shared multiplier
- mul_y_out  output  12  operand y to the shared multiplier
- mul_result_in  input  24  product from the shared multiplier
- rsp_valid_out  output  1  response valid
- rsp_id_out  output  IDW  id of the requester that owns the response
- rsp_data_out  output  24  captured product
- rsp_ready_in  input  1  response consumer ready
- busy_out  output  1  high when state is not IDLE

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values: state=IDLE, rr pointer=NREQ-1 (so requester 0 wins first), mul_x_out=0, mul_y_out=0, rsp_valid_out=0, rsp_id_out=0, rsp_data_out=0, busy_out=0, lat counter=0. req_ready_out=0 while rst_n=0.
- States:
  - IDLE: no transaction.
  - EXEC: operands on the multiplier; lat counter counts MUL_LAT cycles.
  - RESP: response buffer full.
- Grant window, evaluated combinationally:
  - Open when state=IDLE, or when state=RESP and rsp_ready_in=1.
  - Otherwise req_ready_out=0.
- Arbitration: within an open window, grant the first requester with req_valid_in set, searching from rr+1 upward and wrapping modulo NREQ. req_ready_out is the one-hot of that grant, or 0 if no request is valid.
- Accept = req_valid_in[g] & req_ready_out[g]. At the accepting edge:
  - mul_x_out/mul_y_out <= requester g's operands
  - id register <= g
  - rr <= g
  - lat counter <= MUL_LAT-1
  - state <= EXEC
- EXEC:
  - Operands held constant.
  - Counter decrements each cycle.
  - At the edge where counter==0: rsp_data_out <= mul_result_in, rsp_id_out <= id, rsp_valid_out <= 1, state <= RESP.
- Latency: accept at edge E → rsp_valid_out high after edge E+MUL_LAT.
- RESP:
  - rsp_valid_out, rsp_id_out and rsp_data_out are held stable until rsp_ready_in=1.
  - On rsp_ready_in=1 with a new accept in the same cycle: go to EXEC. rsp_valid_out drops to 0 for the EXEC cycles.
  - On rsp_ready_in=1 without an accept: go to IDLE, rsp_valid_out <= 0.
- Throughput: one product per MUL_LAT+1 cycles under continuous backpressure-free traffic.
- Held values: mul_x_out/mul_y_out keep their last values in IDLE/RESP (no toggling). rsp_data_out keeps its last value after drain.
- Requester stability: a requester that drops req_valid_in before being granted is simply not granted. No request is lost once accepted.
- Reset mid-operation: the in-flight transaction is dropped and no response is produced.
- rr is updated only on accept.
- Arithmetic: unsigned. Full 24-bit product, no truncation.

Optional Feature:
- MUL_ARB_FIXED_PRIO_EN defined: fixed priority replaces round-robin. The lowest index with req_valid_in set wins; rr is unused and held at reset value.
- Undefined: round-robin as described. All other behaviour is identical.

Test Plan:
- Single request, MUL_LAT=1: req0 x=12'hFFF, y=12'hFFF.
  → req_ready_out=4'b0001 for one cycle; rsp_valid_out one cycle later with rsp_id_out=0, rsp_data_out=24'hFFE001.
- All four requesters valid continuously, rsp_ready_in=1, operands (3,5),(7,9),(100,200),(4095,1).
  → grant order 0,1,2,3,0. Data 15, 63, 20000, 4095 with matching ids. A new grant on every RESP cycle.
- Backpressure: rsp_ready_in=0 for 10 cycles after the first response, with req1 pending.
  → rsp held stable, req_ready_out=0 throughout. Grant to req1 in the cycle rsp_ready_in returns to 1.
- MUL_LAT=3: req2 x=12'd2048, y=12'd2.
  → mul_x_out stable for 3 cycles; rsp_valid_out rises 3 edges after accept with data 24'd4096, id=2.
- Reset asserted during EXEC with req3 in flight.
  → all outputs return to reset values immediately. No response after rst_n deasserts. First grant after reset goes to req0 if valid.
- With MUL_ARB_FIXED_PRIO_EN, req0 and req2 continuously valid.
  → only req0 is granted. Responses carry id=0 until req0 deasserts, then id=2.
